dmem_pipelined: RTL and testbench

//  Parametrised data memory for the core's load/store path: word-addressed, byte-enabled, with a valid/ready request channel.
//  It also has a valid/ready response channel with configurable read latency.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_if.sv | 38 +++
 rtl/dmem_rsp_pipe.sv | 58 +++++
 rtl/dmem_pipelined.sv | 110 +++++++++++
 tb/tb_dmem_pipelined.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
// Holds the FSM state enum, READ_LAT limits and width helpers.
package dmem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit lat_ok(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the LSU and the data memory.
// master = LSU side, slave = memory side.
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  import dmem_pkg::*;

  localparam int BE_W = be_w(DATA_W);

  logic              init_done;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    input  init_done, req_ready,
    input  rsp_valid, rsp_we, rsp_rdata, rsp_err,
    output req_valid, req_we, req_addr,
    output req_wdata, req_be, rsp_ready
  );

  modport slave (
    output init_done, req_ready,
    output rsp_valid, rsp_we, rsp_rdata, rsp_err,
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be, rsp_ready
  );

endinterface

// File: rtl/dmem_rsp_pipe.sv
// Response shift register, LAT stages deep.
// Every stage moves together on advance; otherwise the pipe holds.
module dmem_rsp_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_we,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t stage_q [LAT];
  stage_t stage_d [LAT];

  // shift all stages on advance, new entry enters stage 0
  always_comb begin
    stage_d = stage_q;
    if (advance) begin
      stage_d[0] = '{valid: in_valid, we: in_we,
                     err: in_err, data: in_data};
      for (int i = 1; i < LAT; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // stage registers; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[LAT-1].valid;
  assign out_we    = stage_q[LAT-1].we;
  assign out_err   = stage_q[LAT-1].err;
  assign out_data  = stage_q[LAT-1].data;

endmodule

// File: rtl/dmem_pipelined.sv
// Byte-enabled data memory with zero-sweep and valid/ready pipe.
// Optional macro DMEM_BOUNDS_ERR_EN flags out-of-range requests.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int PTR_W = ptr_w(DEPTH);

  if (!lat_ok(READ_LAT)) begin : g_lat_chk
    $error("dmem_pipelined: READ_LAT out of range");
  end
  if ((DATA_W % 8) != 0) begin : g_dw_chk
    $error("dmem_pipelined: DATA_W not a multiple of 8");
  end

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              advance;
  logic              accept;
  logic              in_range;
  logic              err_in;
  logic [PTR_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign advance  = !bus.rsp_valid || bus.rsp_ready;
  assign bus.req_ready = (state_q == RUN) && advance;
  assign accept   = bus.req_valid && bus.req_ready;
  assign bus.init_done = (state_q == RUN);

  assign in_range = 64'(bus.req_addr) < 64'(DEPTH);
  assign idx      = bus.req_addr[PTR_W-1:0];
  assign rd_word  = (in_range && !bus.req_we) ? mem[idx] : '0;

`ifdef DMEM_BOUNDS_ERR_EN
  assign err_in = !in_range;
`else
  assign err_in = 1'b0;
`endif

  // sweep pointer walks the array once, then hands over to RUN
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      INIT: begin
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM state and sweep pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // array writes: zero during sweep, byte-masked stores in RUN
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[ptr_q] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  dmem_rsp_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (accept),
    .in_we     (bus.req_we),
    .in_err    (err_in),
    .in_data   (rd_word),
    .out_valid (bus.rsp_valid),
    .out_we    (bus.rsp_we),
    .out_err   (bus.rsp_err),
    .out_data  (bus.rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed testbench for dmem_pipelined.
// DEPTH=16, READ_LAT=3; optional DMEM_BOUNDS_ERR_EN.
module tb_dmem_pipelined;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 32;
  localparam int READ_LAT = 3;

`ifdef DMEM_BOUNDS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  dmem_pipelined #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic drive(input logic we, input int addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = ADDR_W'(addr);
    bus.req_wdata = wd;
    bus.req_be    = be;
  endtask

  // one request, wait for its response (bounded)
  task automatic do_req(input logic we, input int addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic rwe,
                        output logic rerr, output logic ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(we, addr, wd, be);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) ok = 1'b0;
    rd   = bus.rsp_rdata;
    rwe  = bus.rsp_we;
    rerr = bus.rsp_err;
  endtask

  // count cycles until init_done, watching for illegal activity
  task automatic wait_init(output int cyc, output logic rdy_seen,
                           output logic vld_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    vld_seen = 1'b0;
    while (bus.init_done !== 1'b1 && cyc < DEPTH + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.init_done !== 1'b1 && bus.req_ready !== 1'b0)
        rdy_seen = 1'b1;
      if (bus.rsp_valid !== 1'b0) vld_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic rs, vs;
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    tests++;
    if (bus.init_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_init_done got=%0b exp=0", bus.init_done);
    end
    tests++;
    if (bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_req_ready got=%0b exp=0", bus.req_ready);
    end
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_we !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_rsp got v=%0b we=%0b err=%0b d=%h exp 0",
               bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata);
    end
    reset = 1'b0;
    wait_init(cyc, rs, vs);
    tests++;
    if (cyc != DEPTH) begin
      fails++;
      $display("FAIL init_cycles got=%0d exp=%0d", cyc, DEPTH);
    end
    tests++;
    if (rs !== 1'b0) begin
      fails++;
      $display("FAIL init_req_ready got=1 exp=0");
    end
  endtask

  task automatic test_sweep_zero(input string tag);
    logic [31:0] rd;
    logic rwe, rerr, ok;
    for (int a = 0; a < DEPTH; a++) begin
      do_req(1'b0, a, 32'h0, 4'h0, rd, rwe, rerr, ok);
      tests++;
      if (!ok || rd !== 32'h0 || rwe !== 1'b0) begin
        fails++;
        $display("FAIL %s addr=%0d got=%h ok=%0b exp=0", tag, a, rd, ok);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    logic rwe, rerr, ok;
    do_req(1'b1, 5, 32'hDEADBEEF, 4'hF, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h0 || rwe !== 1'b1 || rerr !== 1'b0) begin
      fails++;
      $display("FAIL wr_rsp got d=%h we=%0b err=%0b exp 0/1/0",
               rd, rwe, rerr);
    end
    do_req(1'b1, 5, 32'h000000AA, 4'h1, rd, rwe, rerr, ok);
    do_req(1'b0, 5, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'hDEADBEAA || rwe !== 1'b0) begin
      fails++;
      $display("FAIL be_low got=%h exp=deadbeaa", rd);
    end
    do_req(1'b1, 6, 32'hFFFFFFFF, 4'hF, rd, rwe, rerr, ok);
    do_req(1'b1, 6, 32'h00000000, 4'hA, rd, rwe, rerr, ok);
    do_req(1'b0, 6, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h00FF00FF) begin
      fails++;
      $display("FAIL be_1010 got=%h exp=00ff00ff", rd);
    end
    do_req(1'b1, 6, 32'h12345678, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rwe !== 1'b1) begin
      fails++;
      $display("FAIL be0_rsp ok=%0b we=%0b exp 1/1", ok, rwe);
    end
    do_req(1'b0, 6, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h00FF00FF) begin
      fails++;
      $display("FAIL be0_noop got=%h exp=00ff00ff", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        rwe [3] = '{1'b1, 1'b0, 1'b0};
    int          ra  [3] = '{7, 7, 8};
    logic [31:0] rwd [3] = '{32'h12345678, 32'h0, 32'h0};
    logic [31:0] erd [3] = '{32'h0, 32'h12345678, 32'h0};
    logic ev;
    idle();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      ev = (c >= 3 && c <= 5);
      tests++;
      if (bus.rsp_valid !== ev) begin
        fails++;
        $display("FAIL b2b_valid c=%0d got=%0b exp=%0b",
                 c, bus.rsp_valid, ev);
      end
      if (ev) begin
        tests++;
        if (bus.rsp_rdata !== erd[c-3] || bus.rsp_we !== rwe[c-3]) begin
          fails++;
          $display("FAIL b2b_rsp c=%0d got d=%h we=%0b exp d=%h we=%0b",
                   c, bus.rsp_rdata, bus.rsp_we, erd[c-3], rwe[c-3]);
        end
      end
      if (c < 3) begin
        tests++;
        if (bus.req_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready c=%0d got=%0b exp=1", c, bus.req_ready);
        end
        drive(rwe[c], ra[c], rwd[c], 4'hF);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic rwe, rerr, ok;
    idle();
    repeat (2) @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_second_slot got rdy=%0b v=%0b exp 1/0",
               bus.req_ready, bus.rsp_valid);
    end
    drive(1'b0, 7, 32'h0, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEAA ||
          bus.rsp_we !== 1'b0 || bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold c=%0d got v=%0b d=%h rdy=%0b exp 1/deadbeaa/0",
                 c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
      drive(1'b1, 9, 32'hFFFFFFFF, 4'hF);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345678) begin
      fails++;
      $display("FAIL bp_second got v=%0b d=%h exp 1/12345678",
               bus.rsp_valid, bus.rsp_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL bp_dup c=%0d got v=1 exp 0", c);
      end
    end
    do_req(1'b0, 9, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h0) begin
      fails++;
      $display("FAIL bp_no_accept got=%h exp=0", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic rwe, rerr, ok;
    do_req(1'b1, DEPTH + 3, 32'hFFFFFFFF, 4'hF, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h0 || rwe !== 1'b1 || rerr !== EXP_ERR) begin
      fails++;
      $display("FAIL oor_wr got d=%h we=%0b err=%0b exp 0/1/%0b",
               rd, rwe, rerr, EXP_ERR);
    end
    do_req(1'b0, DEPTH + 3, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h0 || rerr !== EXP_ERR) begin
      fails++;
      $display("FAIL oor_rd got d=%h err=%0b exp 0/%0b", rd, rerr, EXP_ERR);
    end
    do_req(1'b0, 3, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h0 || rerr !== 1'b0) begin
      fails++;
      $display("FAIL oor_alias got d=%h err=%0b exp 0/0", rd, rerr);
    end
    do_req(1'b0, 5, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'hDEADBEAA) begin
      fails++;
      $display("FAIL oor_keep5 got=%h exp=deadbeaa", rd);
    end
    do_req(1'b0, 7, 32'h0, 4'h0, rd, rwe, rerr, ok);
    tests++;
    if (!ok || rd !== 32'h12345678) begin
      fails++;
      $display("FAIL oor_keep7 got=%h exp=12345678", rd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic rs, vs;
    idle();
    repeat (2) @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 7, 32'h0, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rm_pending got v=%0b exp=1", bus.rsp_valid);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.init_done !== 1'b0) begin
      fails++;
      $display("FAIL rm_async got v=%0b done=%0b exp 0/0",
               bus.rsp_valid, bus.init_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_init(cyc, rs, vs);
    tests++;
    if (cyc != DEPTH || rs !== 1'b0) begin
      fails++;
      $display("FAIL rm_init got cyc=%0d rdy=%0b exp %0d/0", cyc, rs, DEPTH);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) vs = 1'b1;
    end
    tests++;
    if (vs !== 1'b0) begin
      fails++;
      $display("FAIL rm_stale got rsp_valid=1 exp 0");
    end
    test_sweep_zero("rm_zero");
  endtask

  initial begin
    idle();
    test_reset();
    test_sweep_zero("sweep_zero");
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
